// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the program-counter sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        INIT,
        FETCH,
        EXEC,
        UPDATE
    } state_e;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0040_0000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0040_0004;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_BR,
        SRC_J,
        SRC_JR,
        SRC_EXC
    } src_e;

    typedef struct packed {
        logic        exc;
        logic        jr_valid;
        logic [31:0] jr_addr;
        logic        j_valid;
        logic [25:0] j_index;
        logic        br_taken;
        logic [15:0] br_off;
    } redirect_t;

endpackage

// File: rtl/npc_select.sv
// Next-PC priority mux: exception, jr, j, branch, then sequential.
module npc_select
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic [31:0] pc_cur,
    input  redirect_t   redir,
    output logic [31:0] pc_next,
    output logic        misalign
);

    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] j_target;
    src_e        src;

    assign pc_plus4  = pc_cur + 32'd4;
    assign br_target = pc_plus4 + {{14{redir.br_off[15]}}, redir.br_off, 2'b00};
    assign j_target  = {pc_plus4[31:28], redir.j_index, 2'b00};

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        src      = SRC_SEQ;
        misalign = 1'b0;
        if (redir.exc) begin
            src = SRC_EXC;
        end else if (redir.jr_valid) begin
            src      = SRC_JR;
            misalign = |redir.jr_addr[1:0];
        end else if (redir.j_valid) begin
            src = SRC_J;
        end else if (redir.br_taken) begin
            src = SRC_BR;
        end
    end

    always_comb begin
        pc_next = pc_plus4;
        case (src)
            SRC_EXC: pc_next = EXC_VECTOR;
            SRC_JR:  pc_next = misalign ? EXC_VECTOR : redir.jr_addr;
            SRC_J:   pc_next = j_target;
            SRC_BR:  pc_next = br_target;
            default: pc_next = pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute/update sequencer driving the pcreg enable and next value.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    output logic        pc_ena,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        ir_latch,
    output logic        exec_start,
    input  logic        exec_done,
    input  logic        br_taken,
    input  logic [15:0] br_off,
    input  logic        j_valid,
    input  logic [25:0] j_index,
    input  logic        jr_valid,
    input  logic [31:0] jr_addr,
    input  logic        exc,
    input  logic        stall,
    output logic        addr_err,
    output logic [31:0] retired
);

    state_e      state_q, state_d;
    logic        exec_first_q, exec_first_d;
    redirect_t   redir_q, redir_d;
    logic [31:0] retired_q, retired_d;
    logic        addr_err_q, addr_err_d;
    logic [31:0] npc;
    logic        misalign;
    logic        commit;

    npc_select #(
        .EXC_VECTOR(EXC_VECTOR)
    ) u_npc (
        .pc_cur  (pc_cur),
        .redir   (redir_q),
        .pc_next (npc),
        .misalign(misalign)
    );

    assign commit = (state_q == UPDATE) && !stall;

    always_comb begin
        state_d      = state_q;
        exec_first_d = 1'b0;
        redir_d      = redir_q;
        retired_d    = retired_q;
        addr_err_d   = addr_err_q;
        case (state_q)
            INIT:  state_d = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    state_d      = EXEC;
                    exec_first_d = 1'b1;
                end
            end
            EXEC: begin
                if (exec_done) begin
                    redir_d.exc      = exc;
                    redir_d.jr_valid = jr_valid;
                    redir_d.jr_addr  = jr_addr;
                    redir_d.j_valid  = j_valid;
                    redir_d.j_index  = j_index;
                    redir_d.br_taken = br_taken;
                    redir_d.br_off   = br_off;
                    state_d          = UPDATE;
                end
            end
            UPDATE: begin
                if (commit) begin
                    state_d   = FETCH;
                    retired_d = retired_q + 32'd1;
                    if (misalign) addr_err_d = 1'b1;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; the captured
    // redirects are reset too so an aborted instruction leaves nothing behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= INIT;
            exec_first_q <= 1'b0;
            redir_q      <= '0;
            retired_q    <= '0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            exec_first_q <= exec_first_d;
            redir_q      <= redir_d;
            retired_q    <= retired_d;
            addr_err_q   <= addr_err_d;
        end
    end

    assign pc_ena     = (state_q == INIT) || commit;
    assign pc_next    = (state_q == INIT) ? RESET_PC : npc;
    assign imem_req   = (state_q == FETCH);
    assign imem_addr  = pc_cur;
    assign ir_latch   = (state_q == FETCH) && imem_ack;
    assign exec_start = (state_q == EXEC) && exec_first_q;
    assign addr_err   = addr_err_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized and directed bench for pc_sequencer with a pcreg model and reference next-PC rules.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC  = 32'h0040_0000;
    localparam logic [31:0] EXC_VEC = 32'h0040_0004;

    logic        clk;
    logic        rst;
    logic [31:0] pc_cur;
    logic        pc_ena;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        ir_latch;
    logic        exec_start;
    logic        exec_done;
    logic        br_taken;
    logic [15:0] br_off;
    logic        j_valid;
    logic [25:0] j_index;
    logic        jr_valid;
    logic [31:0] jr_addr;
    logic        exc;
    logic        stall;
    logic        addr_err;
    logic [31:0] retired;

    int          n_cmp;
    int          n_fail;
    logic [31:0] m_retired;
    logic        m_addr_err;

    pc_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .pc_cur    (pc_cur),
        .pc_ena    (pc_ena),
        .pc_next   (pc_next),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .ir_latch  (ir_latch),
        .exec_start(exec_start),
        .exec_done (exec_done),
        .br_taken  (br_taken),
        .br_off    (br_off),
        .j_valid   (j_valid),
        .j_index   (j_index),
        .jr_valid  (jr_valid),
        .jr_addr   (jr_addr),
        .exc       (exc),
        .stall     (stall),
        .addr_err  (addr_err),
        .retired   (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference next-PC rules written as plain arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic e, input logic jr,
                                               input logic [31:0] ja, input logic j,
                                               input logic [25:0] ji, input logic b,
                                               input logic [15:0] bo);
        logic [31:0] seq;
        seq = pc + 32'd4;
        if (e) return EXC_VEC;
        if (jr) return ((ja % 32'd4) != 0) ? EXC_VEC : ja;
        if (j) return (seq & 32'hF000_0000) | ({6'd0, ji} * 32'd4);
        if (b) return seq + 32'($signed(bo)) * 32'd4;
        return seq;
    endfunction

    // One clock; the pcreg model loads pc_next whenever pc_ena was high.
    task automatic step();
        logic        e;
        logic [31:0] n;
        #1;
        e = pc_ena;
        n = pc_next;
        @(posedge clk);
        if (e) pc_cur = n;
        #1;
    endtask

    task automatic scramble();
        exc      = 1'($urandom());
        jr_valid = 1'($urandom());
        jr_addr  = $urandom();
        j_valid  = 1'($urandom());
        j_index  = 26'($urandom());
        br_taken = 1'($urandom());
        br_off   = 16'($urandom());
    endtask

    task automatic clear_inputs();
        imem_ack  = 1'b0;
        exec_done = 1'b0;
        stall     = 1'b0;
        exc       = 1'b0;
        jr_valid  = 1'b0;
        jr_addr   = '0;
        j_valid   = 1'b0;
        j_index   = '0;
        br_taken  = 1'b0;
        br_off    = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        #1;
        check("rst_pc_ena", pc_ena, 1'b1);
        check("rst_pc_next", pc_next, RST_PC);
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_imem_addr", imem_addr, pc_cur);
        check("rst_ir_latch", ir_latch, 1'b0);
        check("rst_exec_start", exec_start, 1'b0);
        check("rst_addr_err", addr_err, 1'b0);
        check("rst_retired", retired, 32'd0);
        step();
        step();
        rst = 1'b1;
        #1;
        check("init_pc_ena", pc_ena, 1'b1);
        check("init_pc_next", pc_next, RST_PC);
        check("init_imem_req", imem_req, 1'b0);
        step();
        m_retired  = '0;
        m_addr_err = 1'b0;
        check("first_fetch_req", imem_req, 1'b1);
        check("first_fetch_addr", imem_addr, RST_PC);
        check("first_fetch_ena", pc_ena, 1'b0);
    endtask

    task automatic run_instr(input int aw, input int dw, input int sn,
                             input logic e, input logic jr, input logic [31:0] ja,
                             input logic j, input logic [25:0] ji,
                             input logic b, input logic [15:0] bo,
                             output logic [31:0] got);
        logic [31:0] pc0;
        logic [31:0] exp_pc;
        logic        mis;
        pc0 = pc_cur;
        got = 'x;
        for (int i = 0; i <= aw; i++) begin
            imem_ack  = (i == aw);
            exec_done = 1'($urandom());
            stall     = 1'($urandom());
            scramble();
            #1;
            check("fetch_req", imem_req, 1'b1);
            check("fetch_addr", imem_addr, pc0);
            check("ir_latch", ir_latch, imem_ack);
            check("fetch_ena", pc_ena, 1'b0);
            check("fetch_exec_start", exec_start, 1'b0);
            step();
        end
        imem_ack = 1'b0;
        for (int i = 0; i <= dw; i++) begin
            exec_done = (i == dw);
            stall     = 1'($urandom());
            if (i == dw) begin
                exc = e; jr_valid = jr; jr_addr = ja;
                j_valid = j; j_index = ji; br_taken = b; br_off = bo;
            end else begin
                scramble();
            end
            #1;
            check("exec_start", exec_start, (i == 0));
            check("exec_req", imem_req, 1'b0);
            check("exec_ena", pc_ena, 1'b0);
            check("exec_ir_latch", ir_latch, 1'b0);
            step();
        end
        exec_done = 1'b0;
        scramble();
        exp_pc = model_next(pc0, e, jr, ja, j, ji, b, bo);
        mis    = !e && jr && (ja[1:0] != 2'b00);
        for (int i = 0; i <= sn; i++) begin
            stall = (i < sn);
            #1;
            check("update_ena", pc_ena, !stall);
            check("update_req", imem_req, 1'b0);
            if (!stall) begin
                check("pc_next", pc_next, exp_pc);
                got = pc_next;
            end
            step();
        end
        stall = 1'b0;
        m_retired = m_retired + 32'd1;
        if (mis) m_addr_err = 1'b1;
        check("retired", retired, m_retired);
        check("addr_err", addr_err, m_addr_err);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] ja;
        n_cmp      = 0;
        n_fail     = 0;
        m_retired  = '0;
        m_addr_err = 1'b0;
        pc_cur     = 32'h1234_5678;
        clear_inputs();
        rst = 1'b0;
        #2;
        do_reset();

        // Abort during execute: reset wins and nothing retires.
        imem_ack = 1'b1;
        #1;
        check("abort_ir_latch", ir_latch, 1'b1);
        step();
        imem_ack = 1'b0;
        #1;
        check("abort_exec_start", exec_start, 1'b1);
        rst = 1'b0;
        #1;
        check("abort_pc_ena", pc_ena, 1'b1);
        check("abort_pc_next", pc_next, RST_PC);
        check("abort_exec_start_clr", exec_start, 1'b0);
        check("abort_retired", retired, 32'd0);
        do_reset();

        run_instr(0, 0, 0, 0, 0, '0, 0, '0, 0, '0, got);
        check("seq_target", got, 32'h0040_0004);
        check("seq_retired", retired, 32'd1);

        pc_cur = 32'h0040_0010;
        run_instr(0, 1, 0, 0, 0, '0, 0, '0, 1, 16'hFFFC, got);
        check("branch_back", got, 32'h0040_0004);

        pc_cur = 32'h0040_0000;
        run_instr(1, 0, 0, 0, 0, '0, 1, 26'h010_0008, 1, 16'h0040, got);
        check("jump_over_branch", got, 32'h0040_0020);

        run_instr(0, 0, 0, 0, 1, 32'h0040_0102, 1, 26'h3FF_FFFF, 0, '0, got);
        check("jr_misaligned", got, 32'h0040_0004);
        check("jr_addr_err", addr_err, 1'b1);

        run_instr(0, 0, 5, 0, 0, '0, 0, '0, 0, '0, got);
        check("stall_target", got, 32'h0040_0008);

        pc_cur = 32'hFFFF_FFFC;
        run_instr(0, 0, 0, 0, 0, '0, 0, '0, 0, '0, got);
        check("pc_wrap", got, 32'h0000_0000);

        pc_cur = 32'h0040_0100;
        run_instr(0, 0, 0, 1, 1, 32'h0040_0200, 1, '0, 1, '0, got);
        check("exc_priority", got, EXC_VEC);

        run_instr(2, 2, 1, 0, 1, 32'h0080_0000, 1, '0, 1, 16'h0001, got);
        check("jr_aligned", got, 32'h0080_0000);

        for (int k = 0; k < 60; k++) begin
            ja = $urandom();
            if ($urandom_range(0, 2) != 0) ja[1:0] = 2'b00;
            run_instr($urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0), ja,
                      ($urandom_range(0, 3) == 0), 26'($urandom()),
                      ($urandom_range(0, 2) == 0), 16'($urandom()), got);
        end
        check("addr_err_sticky", addr_err, 1'b1);

        do_reset();
        check("final_retired", retired, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle instruction sequencer that owns the enable and next-value inputs of the program-counter register (`pcreg`). It runs the fetch → execute → PC-update cycle of the 31-instruction MIPS core and handshakes with instruction memory. It computes the next PC from sequential, branch, jump, jump-register and exception sources, and counts retired instructions. It sits between the control unit/datapath and `pcreg`, reading `pcreg` output back as the current PC.

## Interface
- `RESET_PC`, default 32'h0040_0000: PC loaded after reset.
- `EXC_VECTOR`, default 32'h0040_0004: PC loaded on exception or misaligned jr.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `pc_cur`  in  32: current PC, fed back from `pcreg` data_out.
- `pc_ena`  out  1: `pcreg` write enable.
- `pc_next`  out  32: `pcreg` data_in.
- `imem_req`  out  1: fetch request.
- `imem_addr`  out  32: fetch address.
- `imem_ack`  in  1: fetch data valid this cycle.
- `ir_latch`  out  1: one-cycle pulse telling the datapath to capture the instruction word.
- `exec_start`  out  1: one-cycle pulse at the start of execute.
- `exec_done`  in  1: datapath finished; redirect inputs are valid this cycle.
- `br_taken`  in  1 and `br_off`  in  16: taken branch and its signed word offset.
- `j_valid`  in  1 and `j_index`  in  26: j/jal and its target index.
- `jr_valid`  in  1 and `jr_addr`  in  32: jr and its register target.
- `exc`  in  1: exception raised by the instruction.
- `stall`  in  1: hold the PC update.
- `addr_err`  out  1: sticky flag, set on a misaligned jr.
- `retired`  out  32: retired-instruction count.

## Operation
- FSM states: INIT, FETCH, EXEC, UPDATE.
- **INIT:** `pc_ena`=1 and `pc_next`=RESET_PC for exactly one cycle, then go to FETCH.
- **FETCH:**
  - `imem_req`=1 and `imem_addr`=`pc_cur`.
  - When `imem_ack`=1: `ir_latch`=1 in the same cycle, then go to EXEC.
  - Otherwise stay in FETCH.
- **EXEC:**
  - `exec_start`=1 on the first cycle in the state only.
  - Wait for `exec_done`.
  - In the `exec_done` cycle, register the redirect inputs into a captured-redirect set, then go to UPDATE.
- **UPDATE:**
  - If `stall`=1: `pc_ena`=0 and stay in UPDATE.
  - If `stall`=0: `pc_ena`=1, `pc_next`=selected target, `retired`+1, then go to FETCH.
- Next-PC priority, computed from the captured redirect set:
  - exc → EXC_VECTOR;
  - jr with `jr_addr[1:0]`≠0 → EXC_VECTOR, and set `addr_err`;
  - jr → `jr_addr`;
  - j → {`pc_plus4`[31:28], `j_index`, 2'b00};
  - br → `pc_plus4` + (sign-extended `br_off` << 2);
  - otherwise → `pc_plus4`.
- `pc_plus4` = `pc_cur` + 4, computed modulo 2^32 with wrap and no flag. All adds are 32-bit and truncate.
- If several redirects are asserted together, only the highest-priority one takes effect.
- `retired` wraps from FFFF_FFFF to 0.
- `addr_err` clears only on reset.
- `stall` is ignored in INIT, FETCH and EXEC.

## Timing
- Reset value of every output:
  - `pc_ena`=1 (INIT is entered asynchronously), `pc_next`=RESET_PC;
  - `imem_req`=0, `imem_addr`=`pc_cur` (combinational);
  - `ir_latch`=0, `exec_start`=0, `addr_err`=0, `retired`=0.
- Reset asserted mid-operation: go to INIT immediately. Captured redirects are cleared and the in-flight instruction is not retired.
- Minimum instruction period: 3 cycles (ack in the first FETCH cycle, `exec_done` in the first EXEC cycle, no stall).
- `pc_ena` rises only in INIT or in UPDATE with `stall`=0. It is never high for two consecutive cycles except INIT→never (FETCH always follows).
- `pcreg` updates at the edge ending UPDATE. The new `pc_cur` is visible in the following FETCH cycle.
- `imem_addr` holds stable for as long as `imem_req` is high.

## Structure
- Shared package `pc_seq_pkg`:
  - state enum (INIT/FETCH/EXEC/UPDATE);
  - RESET_PC and EXC_VECTOR defaults;
  - redirect-source codes (SEQ, BR, J, JR, EXC).
- Sub-module `npc_select`: combinational priority mux and target adders. Inputs are `pc_cur` and the captured redirect set; outputs are `pc_next` and `misalign`.
- Top level contains the FSM, capture registers, `retired` counter and `addr_err`.

## Test plan
- **Reset:** release `rst` → `pc_ena`=1 with `pc_next`=0040_0000 for one cycle; the next cycle shows `imem_req`=1 with `imem_addr`=0040_0000.
- **Sequential:**
  - Stimulus: `pc_cur`=0040_0000, ack and `exec_done` immediate, no redirects.
  - Required: `pc_next`=0040_0004 on the third cycle and `retired`=1.
- **Branch back:** `pc_cur`=0040_0010, `br_taken`, `br_off`=16'hFFFC → `pc_next`=0040_0004.
- **Priority:** `j_valid` with `j_index`=26'h010_0008 plus `br_taken` at `pc_cur`=0040_0000 → `pc_next`=0040_0020 (the jump wins).
- **Misaligned jr:** `jr_addr`=0040_0102 → `pc_next`=0040_0004 and `addr_err`=1. The flag stays high after the following instructions.
- **Stall and reset:**
  - `stall` high for 5 cycles in UPDATE → `pc_ena`=0 throughout, then a single update.
  - `rst` low during EXEC → INIT, and `retired` unchanged at 0.
